if_stage: RTL and testbench

Instruction-fetch stage: owns the architectural fetch PC, issues requests to instruction memory over a request/grant/response handshake, buffers returned instructions in a small FIFO, and presents them to ID through the IF/ID pipeline register. It receives the branch-resolution outputs of the execute stage (redirect flag and 64-bit target) and discards every wrong-path fetch still in flight.

---
 rtl/rv_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-side types: IF/ID pipeline bundle and fetch FSM states.
// Imported by the instruction-fetch stage and its buffers.
package rv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            valid;
    } if_id_regs_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; a pop frees its slot for a same-cycle push.
// Used for both the instruction buffer and the fetch tag queue.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request/grant/response, instruction buffer,
// IF/ID register and wrong-path squashing on EX redirects.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_do_branch,
    input  logic [XLEN-1:0] i_bt,
    input  logic            i_stall,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [ILEN-1:0] i_imem_rdata,
    output if_id_regs_t     o_if_id_regs,
    output logic            o_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam int BW = XLEN + ILEN;

    fetch_state_e    state;
    fetch_state_e    state_nx;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   ibuf_count;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_nx;
    logic [CW-1:0]   inflight;
    logic            drop_dec;
    logic            room;
    logic            accept;
    logic            rsp_take;
    logic            ibuf_pop;
    logic            ibuf_full;
    logic            ibuf_empty;
    logic            tq_full;
    logic            tq_empty;
    logic [XLEN-1:0] tag_pc;
    logic [BW-1:0]   ibuf_head;

    // Buffer slots are reserved at request time so responses never overflow.
    assign room = ({1'b0, outstanding} + {1'b0, ibuf_count})
                < {1'b0, DEPTH_C};

    assign o_imem_req  = (state == RUN) && !i_do_branch && room
                       && !tq_full && !ibuf_full;
    assign o_imem_addr = fetch_pc;

    assign accept   = o_imem_req && i_imem_gnt;
    assign rsp_take = i_imem_rvalid && (state == RUN)
                    && !i_do_branch && !tq_empty;
    assign ibuf_pop = !i_stall && !i_do_branch && !ibuf_empty;

    assign inflight = outstanding + drop_cnt;
    assign drop_dec = i_imem_rvalid && (inflight != '0);

    always_comb begin
        state_nx = state;
        drop_nx  = drop_cnt;
        if (i_do_branch) begin
            drop_nx  = inflight - CW'(drop_dec);
            state_nx = (drop_nx != '0) ? FLUSH : RUN;
        end else begin
            unique case (state)
                BOOT: state_nx = RUN;
                RUN:  state_nx = RUN;
                FLUSH: begin
                    if (i_imem_rvalid && drop_cnt != '0)
                        drop_nx = drop_cnt - CW'(1);
                    if (drop_nx == '0)
                        state_nx = RUN;
                end
                default: state_nx = BOOT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= BOOT;
            drop_cnt     <= '0;
            fetch_pc     <= RESET_PC;
            o_misaligned <= 1'b0;
        end else begin
            state        <= state_nx;
            drop_cnt     <= drop_nx;
            o_misaligned <= i_do_branch && (|i_bt[1:0]);
            if (i_do_branch)
                fetch_pc <= align_word(i_bt);
            else if (accept)
                fetch_pc <= fetch_pc + 64'd4;
        end
    end

    // A redirect squashes the IF/ID slot even while ID is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_if_id_regs <= '0;
        end else if (i_do_branch) begin
            o_if_id_regs.valid <= 1'b0;
        end else if (!i_stall) begin
            if (ibuf_pop) begin
                o_if_id_regs.pc    <= ibuf_head[BW-1:ILEN];
                o_if_id_regs.inst  <= ibuf_head[ILEN-1:0];
                o_if_id_regs.valid <= 1'b1;
            end else begin
                o_if_id_regs.valid <= 1'b0;
            end
        end
    end

    // Tag queue depth doubles as the count of live requests.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_tagq (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (accept),
        .pop   (rsp_take),
        .clear (i_do_branch),
        .din   (fetch_pc),
        .dout  (tag_pc),
        .count (outstanding),
        .full  (tq_full),
        .empty (tq_empty)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BW)
    ) u_ibuf (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (rsp_take),
        .pop   (ibuf_pop),
        .clear (i_do_branch),
        .din   ({tag_pc, i_imem_rdata}),
        .dout  (ibuf_head),
        .count (ibuf_count),
        .full  (ibuf_full),
        .empty (ibuf_empty)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed + random bench for if_stage: in-order memory model with
// grant/response delays and a pc/inst scoreboard on the IF/ID output.
module tb_if_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        do_branch;
    logic [63:0] bt;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    if_id_regs_t ifid;
    logic        misaligned;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_do_branch   (do_branch),
        .i_bt          (bt),
        .i_stall       (stall),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_if_id_regs  (ifid),
        .o_misaligned  (misaligned)
    );

    typedef struct {
        logic [63:0] addr;
        int          ready;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    logic [63:0] ref_pc = 64'h0;
    logic [63:0] tgt = 64'h1;
    logic        got = 1'b0;
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          gwait = 0;
    int          gnt_max = 0;
    int          rsp_max = 0;
    int          rsp_fix = 0;
    logic        exp_mis = 1'b0;
    logic        prev_br = 1'b0;
    logic        prev_st = 1'b0;
    if_id_regs_t prev_ifid;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chkr(input string tag, input if_id_regs_t obs,
                        input if_id_regs_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Negedge sampling: memory bookkeeping, scoreboard and protocol checks.
    task automatic sample();
        logic [63:0] e;
        if (imem_rvalid)
            void'(pend.pop_front());
        if (imem_req && imem_gnt) begin
            chk64("imem_addr", imem_addr, ref_pc);
            exp_q.push_back(ref_pc);
            ref_pc = ref_pc + 64'd4;
            pend.push_back('{addr: imem_addr,
                             ready: cyc + 1 + rsp_fix
                                    + int'($urandom_range(0, rsp_max))});
            gwait = int'($urandom_range(0, gnt_max));
        end else if (imem_req && gwait > 0) begin
            gwait--;
        end
        chk1("inflight_cap", pend.size() <= 4, 1'b1);
        chk1("misaligned", misaligned, exp_mis);
        if (prev_br)
            chk1("valid_after_redirect", ifid.valid, 1'b0);
        if (prev_st && !prev_br)
            chkr("stall_hold", ifid, prev_ifid);
        if (do_branch)
            chk1("req_in_redirect", imem_req, 1'b0);
        if (ifid.valid && !stall && !do_branch) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            chk64("deliver_pc", ifid.pc, e);
            chk64("deliver_inst", {32'h0, ifid.inst}, {32'h0, mem_word(e)});
            if (ifid.pc === tgt)
                got = 1'b1;
        end
        exp_mis   = do_branch && (|bt[1:0]);
        prev_br   = do_branch;
        prev_st   = stall;
        prev_ifid = ifid;
    endtask

    initial begin : mem_model
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                pend.delete();
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                gwait       = 0;
            end else begin
                cyc++;
                imem_rvalid = (pend.size() > 0) && (pend[0].ready <= cyc);
                imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : '0;
                imem_gnt    = imem_req && (gwait == 0);
                @(negedge clk);
                sample();
            end
        end
    end

    task automatic redirect(input logic [63:0] t, input logic st);
        @(posedge clk);
        #1;
        do_branch = 1'b1;
        bt        = t;
        stall     = st;
        exp_q.delete();
        ref_pc    = align_word(t);
        tgt       = ref_pc;
        got       = 1'b0;
        @(posedge clk);
        #1;
        do_branch = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic wait_target(input string tag);
        int n = 0;
        while (!got && n < 80) begin
            @(posedge clk);
            n++;
        end
        chk1(tag, got, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin : stim
        rst_n     = 1'b0;
        stall     = 1'b0;
        do_branch = 1'b0;
        bt        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk64("rst_addr", imem_addr, 64'h0);
        chkr("rst_ifid", ifid, '0);
        chk1("rst_mis", misaligned, 1'b0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        #3 chk1("boot_req", imem_req, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #4;
            chk1("first_valid", ifid.valid, k == 4);
            if (k == 1)
                chk1("run_req", imem_req, 1'b1);
        end
        chk64("first_pc", ifid.pc, 64'h0);
        chk64("first_inst", {32'h0, ifid.inst}, {32'h0, mem_word(64'h0)});
        repeat (8) begin
            @(posedge clk);
            #4 chk1("stream_valid", ifid.valid, 1'b1);
        end

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 stall = 1'b1;
            #3;
            if (i == 2)
                chk1("stall_req_stop", imem_req, 1'b0);
        end
        @(posedge clk);
        #1 stall = 1'b0;
        @(posedge clk);
        #4 chk1("stall_resume", imem_req, 1'b1);
        repeat (6) @(posedge clk);

        #1 rsp_fix = 2;
        repeat (6) @(posedge clk);
        redirect(64'h1000, 1'b0);
        rsp_fix = 0;
        wait_target("redirect_1000");

        repeat (4) @(posedge clk);
        redirect(64'h2000, 1'b1);
        wait_target("redirect_stall_2000");

        repeat (4) @(posedge clk);
        redirect(64'h1002, 1'b0);
        #3 chk1("misaligned_pulse", misaligned, 1'b1);
        @(posedge clk);
        #4 chk1("misaligned_clear", misaligned, 1'b0);
        wait_target("redirect_misaligned");

        redirect(64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        wait_target("redirect_wrap");
        repeat (8) @(posedge clk);

        gnt_max = 5;
        rsp_max = 5;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1 stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0)
                redirect({$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end

        @(posedge clk);
        #1;
        stall   = 1'b0;
        gnt_max = 0;
        rsp_max = 0;
        redirect(64'h8000, 1'b0);
        wait_target("final_recover");
        repeat (4) begin
            @(posedge clk);
            #4 chk1("final_stream", ifid.valid, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
